// File: rtl/uart_watch_dog_pkg.sv
// Shared definitions for the multi-channel activity watchdog.
//   ch_state_t    : per-channel state encoding (IDLE, WAIT, ACTIVE, TIMEOUT)
//   DEF_NCH       : default number of monitored channels
//   DEF_CNT_W     : default timeout counter / preset width
package uart_watch_dog_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACTIVE  = 2'd2,
        TIMEOUT = 2'd3
    } ch_state_t;

endpackage

// File: rtl/uart_watch_dog_ch.sv
// One watchdog channel: activity detector, state machine and timeout counter.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : channel enable; low forces IDLE with a cleared counter
//   mode          : 0 = any edge counts as activity, 1 = high level counts
//   sample        : monitored signal, already in the clk domain
//   reload        : reload value to use this cycle (bypass already resolved)
//   active_state  : high while the channel is in ACTIVE
//   active        : one-cycle pulse on entry to ACTIVE
//   inactive      : one-cycle pulse on entry to TIMEOUT
//   timeout_evt   : combinational "entering TIMEOUT at this edge", lets the
//                   parent set its sticky flag on the same edge as inactive
module uart_watch_dog_ch
    import uart_watch_dog_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sample,
    input  logic [CNT_W-1:0] reload,
    output logic             active_state,
    output logic             active,
    output logic             inactive,
    output logic             timeout_evt
);

    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             prev_reg;
    logic             active_reg, active_next;
    logic             inactive_reg, inactive_next;
    logic             act;

    // Previous sample keeps tracking even while disabled so that enabling a
    // channel never produces a spurious edge.
    assign act = mode ? sample : (sample ^ prev_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            prev_reg     <= 1'b0;
            active_reg   <= 1'b0;
            inactive_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            prev_reg     <= sample;
            active_reg   <= active_next;
            inactive_reg <= inactive_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        active_next   = 1'b0;
        inactive_next = 1'b0;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: state_next = WAIT;
                WAIT, TIMEOUT: begin
                    if (act) begin
                        state_next  = ACTIVE;
                        cnt_next    = reload;
                        active_next = 1'b1;
                    end
                end
                ACTIVE: begin
                    // Counter reaches 0 after reload edges; the following
                    // quiet edge times out, giving reload+1 cycles in total.
                    if (act) begin
                        cnt_next = reload;
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_next    = TIMEOUT;
                        inactive_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign active_state = (state_reg == ACTIVE);
    assign active       = active_reg;
    assign inactive     = inactive_reg;
    assign timeout_evt  = inactive_next;

endmodule

// File: rtl/uart_watch_dog_mc.sv
// Multi-channel activity watchdog with a shared reload register.
// Optional build macro: UART_WATCH_DOG_SYNC_EN adds a 2-flop synchroniser on
// every monitor_in bit (2 extra cycles of detection latency).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en, mode   : per-channel enable and activity type
//   load       : strobe writing preset into the reload register
//   preset     : timeout reload value
//   monitor_in : monitored signals
//   clr        : clears the sticky timeout flags (a new timeout wins)
//   state      : per-channel "in ACTIVE"
//   active     : per-channel entry-to-ACTIVE pulse
//   inactive   : per-channel entry-to-TIMEOUT pulse
//   to_flag    : sticky per-channel timeout flags
//   irq        : OR of to_flag
module uart_watch_dog_mc
    import uart_watch_dog_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic             load,
    input  logic [CNT_W-1:0] preset,
    input  logic [NCH-1:0]   monitor_in,
    input  logic             clr,
    output logic [NCH-1:0]   state,
    output logic [NCH-1:0]   active,
    output logic [NCH-1:0]   inactive,
    output logic [NCH-1:0]   to_flag,
    output logic             irq
);

    logic [CNT_W-1:0] reload_reg;
    logic [CNT_W-1:0] reload_eff;
    logic [NCH-1:0]   to_flag_reg;
    logic [NCH-1:0]   timeout_evt;
    logic [NCH-1:0]   sample;

`ifdef UART_WATCH_DOG_SYNC_EN
    logic [NCH-1:0] sync1_reg, sync2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= monitor_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign sample = sync2_reg;
`else
    assign sample = monitor_in;
`endif

    // A reload coinciding with load must see the new preset, not the old
    // register contents.
    assign reload_eff = load ? preset : reload_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_reg <= '1;
        end else if (load) begin
            reload_reg <= preset;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            uart_watch_dog_ch #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .en          (en[gi]),
                .mode        (mode[gi]),
                .sample      (sample[gi]),
                .reload      (reload_eff),
                .active_state(state[gi]),
                .active      (active[gi]),
                .inactive    (inactive[gi]),
                .timeout_evt (timeout_evt[gi])
            );

            // Set has priority over clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    to_flag_reg[gi] <= 1'b0;
                end else if (timeout_evt[gi]) begin
                    to_flag_reg[gi] <= 1'b1;
                end else if (clr) begin
                    to_flag_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign to_flag = to_flag_reg;
    assign irq     = |to_flag_reg;

endmodule

// File: doc/uart_watch_dog_mc.md
UART_WATCH_DOG_MC -- requirements
Module: uart_watch_dog_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent monitored channels, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 32: width of the timeout counter and preset, range 2..32.
REQ-003 SHALL have port clk, input, 1: single clock; all logic sits on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, NCH: per-channel enable.
REQ-006 SHALL have port mode, input, NCH: per-channel activity type; 0 = any edge on monitor_in, 1 = high level.
REQ-007 SHALL have port load, input, 1: a one-cycle strobe that writes preset into the shared reload register.
REQ-008 SHALL have port preset, input, CNT_W: the timeout reload value.
REQ-009 SHALL have port monitor_in, input, NCH: the monitored signals.
REQ-010 SHALL have port clr, input, 1: clears the sticky timeout flags.
REQ-011 SHALL have port state, output, NCH: 1 while the channel is in ACTIVE.
REQ-012 SHALL have port active, output, NCH: a one-cycle pulse on entry to ACTIVE.
REQ-013 SHALL have port inactive, output, NCH: a one-cycle pulse on entry to TIMEOUT.
REQ-014 SHALL have port to_flag, output, NCH: sticky timeout flags.
REQ-015 SHALL have port irq, output, 1: OR-reduction of to_flag.

Function
REQ-016 Each channel SHALL derive act: if mode=0, act = sample XOR previous sample; if mode=1, act = sample.
REQ-017 Each channel SHALL have states IDLE, WAIT and ACTIVE, plus TIMEOUT; en=0 SHALL force IDLE in every state, with counter cleared and no pulses.
REQ-018 IDLE with en=1 SHALL go to WAIT on the next cycle.
REQ-019 WAIT or TIMEOUT with act=1 SHALL go to ACTIVE, load the counter with the reload value and pulse active for one cycle.
REQ-020 ACTIVE with act=1 SHALL reload the counter; with act=0 and counter>0 it SHALL decrement; with act=0 and counter=0 it SHALL go to TIMEOUT, pulse inactive and set to_flag.
REQ-021 The last act cycle to the inactive pulse SHALL be exactly reload+1 cycles, so reload=0 times out on the cycle after the last activity.
REQ-022 load SHALL update the reload register on the next edge; any reload occurring in the same cycle as load SHALL use preset directly (bypass), never the old value.
REQ-023 A counter already running SHALL NOT be altered by load until its next reload.
REQ-024 to_flag[i] SHALL stay at 1 until clr; when clr and a new timeout coincide, the set SHALL win.
REQ-025 state, active and inactive SHALL all be registered; active and inactive SHALL never be high in the same cycle.
REQ-026 The counter SHALL never wrap: it holds at 0 once in TIMEOUT.

Reset
REQ-027 rst SHALL asynchronously force: all channels to IDLE, counters to 0, reload register to all-ones, previous-sample registers to 0, and all outputs to 0.
REQ-028 Release of rst SHALL take effect at the first clk edge at which rst is low; a reset in mid-count SHALL lose the count with no inactive pulse.

Configuration
REQ-029 With macro UART_WATCH_DOG_SYNC_EN defined, monitor_in SHALL pass through a 2-flop synchroniser per channel, adding 2 cycles to activity detection.
REQ-030 Without UART_WATCH_DOG_SYNC_EN, monitor_in SHALL be sampled directly, as it is assumed synchronous to clk.

Structure
REQ-031 Package uart_watch_dog_pkg SHALL hold the channel state enum (IDLE, WAIT, ACTIVE, TIMEOUT) and the default parameter constants.
REQ-032 The per-channel FSM, counter and edge detector SHALL be sub-module uart_watch_dog_ch, instantiated NCH times in a generate loop.
REQ-033 The reload register, to_flag, irq and the synchroniser SHALL stay in the top module.

Verification (NCH=2, CNT_W=8, sync macro off)
REQ-034 The bench SHALL cover: load preset=8'h0F, mode=0, en=1, toggle monitor_in[0] once -> active[0] pulses 1 cycle later, inactive[0] exactly 16 cycles after the toggle, to_flag[0]=1 and irq=1.
REQ-035 The bench SHALL cover: mode=1, monitor_in[1] held high 100 cycles with preset=8'h05 -> state[1] stays 1 and no inactive; after release, inactive[1] comes 6 cycles later.
REQ-036 The bench SHALL cover: load preset=8'h03 in the same cycle as the first activity -> the timeout comes 4 cycles after that activity, not using the reset-default reload of 8'hFF.
REQ-037 The bench SHALL cover: clr asserted in the same cycle as a new timeout on channel 0 -> to_flag[0] remains 1.
REQ-038 The bench SHALL cover: en[0] dropped mid-count -> state[0]=0 on the next cycle, with no inactive pulse; after re-enable the channel sits in WAIT until activity.
REQ-039 The bench SHALL cover: rst asserted mid-count -> all outputs 0 immediately, without waiting for a clk edge.
